// File: rtl/stream_fifo_pkg.sv
// Shared types and sizing helpers for the threshold stream FIFO.
// The optional STREAM_FIFO_WATERMARK_EN macro is consumed by stream_fifo_th.
`ifndef STREAM_FIFO_TH_CFG_T
`define STREAM_FIFO_TH_CFG_T(W) struct packed { \
  logic [(W)-1:0] alm_full_th; \
  logic [(W)-1:0] alm_empty_th; \
}
`endif

package stream_fifo_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// Modulo-DEPTH wrap counter with enable and synchronous clear.
// Used for both FIFO read and write pointers.
module stream_fifo_ptr
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0
            : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_fifo_th.sv
// Valid/ready FIFO with fill level and runtime almost-full/empty thresholds.
// Define STREAM_FIFO_WATERMARK_EN to add the max_usage_o high-water register.
module stream_fifo_th
  import stream_fifo_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned CNT_W       = cnt_width(DEPTH),
  localparam int unsigned ADDR_W      = addr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  dtype             data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output dtype             data_o,
  output logic [CNT_W-1:0] usage_o,
  input  logic [CNT_W-1:0] alm_full_th_i,
  input  logic [CNT_W-1:0] alm_empty_th_i,
  output logic             alm_full_o,
  output logic             alm_empty_o,
  output logic [CNT_W-1:0] max_usage_o
);

  if (DEPTH < 1 || DEPTH > 65536) begin : g_depth_err
    $error("stream_fifo_th: DEPTH must be in 1..65536");
  end

  typedef `STREAM_FIFO_TH_CFG_T(CNT_W) th_cfg_t;

  th_cfg_t           th_cfg;
  dtype              mem_q [DEPTH];
  logic [CNT_W-1:0]  count_d, count_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, empty, bypass;
  logic              push_hs, pop_hs;
  logic              push_en, pop_en, we;

  assign th_cfg.alm_full_th  = alm_full_th_i;
  assign th_cfg.alm_empty_th = alm_empty_th_i;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign bypass = FALL_THROUGH && empty;

  assign ready_o = !full;
  assign valid_o = bypass ? valid_i : !empty;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr];

  assign push_hs = valid_i && ready_o;
  assign pop_hs  = valid_o && ready_i;

  // A bypassed item never touches storage or the count.
  assign push_en = push_hs && !(bypass && pop_hs);
  assign pop_en  = pop_hs && !bypass;
  assign we      = push_en && !flush_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_en && !pop_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_en && !push_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_ptr] <= data_i;
  end

  stream_fifo_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .en_i   (we),
    .ptr_o  (wr_ptr)
  );

  stream_fifo_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .en_i   (pop_en),
    .ptr_o  (rd_ptr)
  );

  assign usage_o     = count_q;
  assign alm_full_o  = (th_cfg.alm_full_th != '0) &&
                       (count_q >= th_cfg.alm_full_th);
  assign alm_empty_o = (count_q <= th_cfg.alm_empty_th);

`ifdef STREAM_FIFO_WATERMARK_EN
  logic [CNT_W-1:0] max_d, max_q;

  always_comb begin
    max_d = max_q;
    if (flush_i)              max_d = '0;
    else if (count_d > max_q) max_d = count_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) max_q <= '0;
    else         max_q <= max_d;
  end

  assign max_usage_o = max_q;
`else
  assign max_usage_o = '0;
`endif

`ifndef SYNTHESIS
  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(we && full));

  a_no_pop_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(pop_en && empty));

  a_valid_hold: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o && !flush_i) |=> valid_i);
`endif

endmodule

// File: tb/tb_stream_fifo_th.sv
// Scoreboard bench for stream_fifo_th: three instances cover normal,
// fall-through and threshold/flush/watermark/reset behaviour.
module tb_stream_fifo_th;

`ifdef STREAM_FIFO_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // u5: DEPTH=5 normal mode
  logic        a_flush = 0, a_valid = 0, a_ready = 0;
  logic [31:0] a_data = 0, a_data_o;
  logic        a_ready_o, a_valid_o, a_afull, a_aempty;
  logic [2:0]  a_usage, a_max;
  logic [2:0]  a_fth = 3'd5, a_eth = 3'd0;
  logic [31:0] qa[$];

  stream_fifo_th #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(5)) u5 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .valid_i(a_valid), .ready_o(a_ready_o), .data_i(a_data),
    .valid_o(a_valid_o), .ready_i(a_ready), .data_o(a_data_o),
    .usage_o(a_usage), .alm_full_th_i(a_fth), .alm_empty_th_i(a_eth),
    .alm_full_o(a_afull), .alm_empty_o(a_aempty), .max_usage_o(a_max));

  // u8: DEPTH=8 normal mode
  logic        b_flush = 0, b_valid = 0, b_ready = 0;
  logic [31:0] b_data = 0, b_data_o;
  logic        b_ready_o, b_valid_o, b_afull, b_aempty;
  logic [3:0]  b_usage, b_max;
  logic [3:0]  b_fth = 4'd6, b_eth = 4'd2;
  logic [31:0] qb[$];

  stream_fifo_th #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .valid_i(b_valid), .ready_o(b_ready_o), .data_i(b_data),
    .valid_o(b_valid_o), .ready_i(b_ready), .data_o(b_data_o),
    .usage_o(b_usage), .alm_full_th_i(b_fth), .alm_empty_th_i(b_eth),
    .alm_full_o(b_afull), .alm_empty_o(b_aempty), .max_usage_o(b_max));

  // uf: DEPTH=4 fall-through
  logic        c_flush = 0, c_valid = 0, c_ready = 0;
  logic [31:0] c_data = 0, c_data_o;
  logic        c_ready_o, c_valid_o, c_afull, c_aempty;
  logic [2:0]  c_usage, c_max;
  logic [2:0]  c_fth = 3'd4, c_eth = 3'd0;
  logic [31:0] qc[$];

  stream_fifo_th #(.FALL_THROUGH(1'b1), .DATA_WIDTH(32), .DEPTH(4)) uf (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush),
    .valid_i(c_valid), .ready_o(c_ready_o), .data_i(c_data),
    .valid_o(c_valid_o), .ready_i(c_ready), .data_o(c_data_o),
    .usage_o(c_usage), .alm_full_th_i(c_fth), .alm_empty_th_i(c_eth),
    .alm_full_o(c_afull), .alm_empty_o(c_aempty), .max_usage_o(c_max));

  // Monitors: compare each delivered item against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && a_valid_o && a_ready) begin
      if (qa.size() == 0) chk("u5_unexpected", a_data_o, 32'hxxxx_xxxx);
      else                chk("u5_data", a_data_o, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_valid_o && b_ready) begin
      if (qb.size() == 0) chk("u8_unexpected", b_data_o, 32'hxxxx_xxxx);
      else                chk("u8_data", b_data_o, qb.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_valid_o && c_ready) begin
      if (qc.size() == 0) chk("uf_unexpected", c_data_o, 32'hxxxx_xxxx);
      else                chk("uf_data", c_data_o, qc.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, got timeout expected end");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_ready", {31'b0, a_ready_o}, 1);
    chk("rst_valid", {31'b0, a_valid_o}, 0);
    chk("rst_usage", {29'b0, a_usage}, 0);
    chk("rst_aempty", {31'b0, a_aempty}, 1);
    chk("rst_afull", {31'b0, a_afull}, 0);
    chk("rst_max", {29'b0, a_max}, 0);
    chk("rst_ft_valid", {31'b0, c_valid_o}, 0);
    #10 rst_n = 1'b1;
    tick();

    // DEPTH=5 fill, drain, refill across the wrap
    for (int i = 0; i < 5; i++) begin
      a_valid = 1; a_data = 32'hA0 + i; qa.push_back(a_data);
      tick();
    end
    a_valid = 0;
    chk("u5_full_ready", {31'b0, a_ready_o}, 0);
    chk("u5_full_usage", {29'b0, a_usage}, 5);
    chk("u5_full_afull", {31'b0, a_afull}, 1);
    a_ready = 1;
    tick();
    chk("u5_pop1_ready", {31'b0, a_ready_o}, 1);
    repeat (4) tick();
    a_ready = 0;
    chk("u5_drain_usage", {29'b0, a_usage}, 0);
    chk("u5_drain_valid", {31'b0, a_valid_o}, 0);
    for (int i = 0; i < 5; i++) begin
      a_valid = 1; a_data = 32'hB0 + i; qa.push_back(a_data);
      tick();
    end
    // Full with a pending push: pop frees a slot, refill next cycle
    a_valid = 1; a_data = 32'hC0; a_ready = 1;
    chk("u5_full2_ready", {31'b0, a_ready_o}, 0);
    tick();
    chk("u5_nosame_ready", {31'b0, a_ready_o}, 1);
    chk("u5_nosame_usage", {29'b0, a_usage}, 4);
    qa.push_back(32'hC0);
    tick();
    a_valid = 0;
    chk("u5_pp_usage", {29'b0, a_usage}, 4);
    repeat (4) tick();
    a_ready = 0;
    chk("u5_end_usage", {29'b0, a_usage}, 0);

    // Fall-through bypass and stored path
    qc.push_back(32'h55);
    c_valid = 1; c_data = 32'h55; c_ready = 1;
    #1;
    chk("ft_valid", {31'b0, c_valid_o}, 1);
    chk("ft_data", c_data_o, 32'h55);
    tick();
    chk("ft_bypass_usage", {29'b0, c_usage}, 0);
    c_ready = 0; c_data = 32'h66; qc.push_back(32'h66);
    #1;
    chk("ft_data2", c_data_o, 32'h66);
    tick();
    c_valid = 0;
    chk("ft_store_usage", {29'b0, c_usage}, 1);
    chk("ft_store_data", c_data_o, 32'h66);
    c_ready = 1;
    tick();
    c_ready = 0;
    chk("ft_end_usage", {29'b0, c_usage}, 0);
    chk("ft_end_valid", {31'b0, c_valid_o}, 0);

    // DEPTH=8 thresholds: full_th=6, empty_th=2
    for (int i = 0; i < 7; i++) begin
      b_valid = 1; b_data = 32'h10 + i; qb.push_back(b_data);
      tick();
      chk("u8_usage", {28'b0, b_usage}, i + 1);
      chk("u8_aempty", {31'b0, b_aempty}, (i + 1 <= 2) ? 1 : 0);
      chk("u8_afull", {31'b0, b_afull}, (i + 1 >= 6) ? 1 : 0);
    end
    b_valid = 0;
    chk("u8_max7", {28'b0, b_max}, WM ? 7 : 0);
    b_fth = 4'd0;
    #1;
    chk("u8_th0_afull", {31'b0, b_afull}, 0);
    b_fth = 4'd15;
    #1;
    chk("u8_thbig_afull", {31'b0, b_afull}, 0);
    b_fth = 4'd6;
    b_ready = 1;
    repeat (4) tick();
    chk("u8_usage3", {28'b0, b_usage}, 3);
    for (int k = 0; k < 10; k++) begin
      b_valid = 1; b_data = 32'h20 + k; qb.push_back(b_data);
      tick();
      chk("u8_pp_usage", {28'b0, b_usage}, 3);
    end
    b_ready = 0;
    b_data = 32'h30; qb.push_back(b_data);
    tick();
    chk("u8_usage4", {28'b0, b_usage}, 4);

    // Flush beats a concurrent push and pop
    b_flush = 1; b_valid = 1; b_ready = 1; b_data = 32'h99;
    tick();
    qb.delete();
    b_flush = 0; b_valid = 0; b_ready = 0;
    chk("u8_flush_usage", {28'b0, b_usage}, 0);
    chk("u8_flush_valid", {31'b0, b_valid_o}, 0);
    chk("u8_flush_max", {28'b0, b_max}, 0);

    // Watermark: push 6, pop 4, push 1, flush
    for (int i = 0; i < 6; i++) begin
      b_valid = 1; b_data = 32'h50 + i; qb.push_back(b_data);
      tick();
    end
    b_valid = 0;
    chk("wm_push6", {28'b0, b_max}, WM ? 6 : 0);
    b_ready = 1;
    repeat (4) tick();
    b_ready = 0;
    chk("wm_pop4", {28'b0, b_max}, WM ? 6 : 0);
    b_valid = 1; b_data = 32'h56; qb.push_back(b_data);
    tick();
    b_valid = 0;
    chk("wm_push1_usage", {28'b0, b_usage}, 3);
    chk("wm_push1", {28'b0, b_max}, WM ? 6 : 0);
    b_flush = 1;
    tick();
    b_flush = 0;
    qb.delete();
    chk("wm_flush", {28'b0, b_max}, 0);
    chk("wm_flush_usage", {28'b0, b_usage}, 0);

    // Asynchronous reset at usage 6
    for (int i = 0; i < 6; i++) begin
      b_valid = 1; b_data = 32'h40 + i; qb.push_back(b_data);
      tick();
    end
    b_valid = 0;
    chk("ar_usage6", {28'b0, b_usage}, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_usage", {28'b0, b_usage}, 0);
    chk("ar_valid", {31'b0, b_valid_o}, 0);
    chk("ar_ready", {31'b0, b_ready_o}, 1);
    chk("ar_aempty", {31'b0, b_aempty}, 1);
    chk("ar_afull", {31'b0, b_afull}, 0);
    chk("ar_max", {28'b0, b_max}, 0);
    qb.delete();
    #10 rst_n = 1'b1;
    tick();
    b_valid = 1; b_data = 32'h77; qb.push_back(b_data);
    tick();
    b_valid = 0; b_ready = 1;
    tick();
    b_ready = 0;
    chk("ar_after_usage", {28'b0, b_usage}, 0);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
